// File: rtl/addroundkey_pipe.sv
// Streaming AES AddRoundKey stage: XORs LANES-byte state beats with a stored round key.
// Optional ARK_SKID_EN adds a 2-entry skid buffer behind the output register.
module addroundkey_pipe #(
  parameter int BLOCK_BYTES = 16,
  parameter int LANES       = 4,
  parameter int NKEYS       = 11,
  localparam int KW         = (NKEYS > 1) ? $clog2(NKEYS) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     key_wr_en,
  input  logic [KW-1:0]            key_wr_idx,
  input  logic [8*BLOCK_BYTES-1:0] key_wr_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [8*LANES-1:0]       in_data,
  input  logic [KW-1:0]            in_round,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [8*LANES-1:0]       out_data,
  output logic                     out_last,
  output logic                     err_round
);

  localparam int BEATS = BLOCK_BYTES / LANES;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int BW    = 8 * LANES;
  localparam int KB    = 8 * BLOCK_BYTES;
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

  logic [KB-1:0] key_mem [NKEYS];
  logic [KB-1:0] wkey;
  logic [KB-1:0] sel_key;
  logic [KB-1:0] cur_key;
  logic [CW-1:0] beat_cnt;
  logic [BW-1:0] key_slice;
  logic [BW-1:0] result;
  logic          round_ok;
  logic          in_fire;
  logic          is_last;

  assign in_fire = in_valid && in_ready;
  assign is_last = (beat_cnt == LAST_BEAT);

  // Key chosen for a block that starts this cycle; a same-cycle write to that entry wins.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    sel_key  = '0;
    round_ok = 1'b0;
    for (int k = 0; k < NKEYS; k++) begin
      if (in_round == KW'(k)) begin
        sel_key  = key_mem[k];
        round_ok = 1'b1;
      end
    end
    if (round_ok && key_wr_en && (key_wr_idx == in_round)) begin
      sel_key = key_wr_data;
    end
  end

  always_comb begin
    cur_key   = (beat_cnt == '0) ? sel_key : wkey;
    key_slice = '0;
    for (int b = 0; b < BEATS; b++) begin
      if (beat_cnt == CW'(b)) begin
        key_slice = cur_key[b*BW +: BW];
      end
    end
    result = in_data ^ key_slice;
  end

  // NOTE: the key store is cleared on reset, so it is built from flops rather than a RAM macro.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NKEYS; k++) begin
        key_mem[k] <= '0;
      end
    end else if (key_wr_en) begin
      for (int k = 0; k < NKEYS; k++) begin
        if (key_wr_idx == KW'(k)) begin
          key_mem[k] <= key_wr_data;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      wkey      <= '0;
      beat_cnt  <= '0;
      err_round <= 1'b0;
    end else if (in_fire) begin
      if (beat_cnt == '0) begin
        wkey <= sel_key;
        if (!round_ok) begin
          err_round <= 1'b1;
        end
      end
      beat_cnt <= is_last ? '0 : beat_cnt + CW'(1);
    end
  end

`ifdef ARK_SKID_EN

  // Entry 0 is the output register; entries 1..2 form the skid buffer behind it.
  logic [BW:0] q   [3];
  logic [BW:0] q_n [3];
  logic [1:0]  cnt;
  logic [1:0]  cnt_n;
  logic [1:0]  wr_pos;
  logic        pop;
  logic        in_ready_r;

  assign pop       = (cnt != 2'd0) && out_ready;
  assign out_valid = (cnt != 2'd0);
  assign out_data  = q[0][BW-1:0];
  assign out_last  = q[0][BW];
  assign in_ready  = in_ready_r && !reset;

  always_comb begin
    q_n    = q;
    cnt_n  = cnt;
    wr_pos = cnt;
    if (pop) begin
      q_n[0] = q[1];
      q_n[1] = q[2];
      cnt_n  = cnt - 2'd1;
      wr_pos = cnt - 2'd1;
    end
    if (in_fire) begin
      case (wr_pos)
        2'd0:    q_n[0] = {is_last, result};
        2'd1:    q_n[1] = {is_last, result};
        default: q_n[2] = {is_last, result};
      endcase
      cnt_n = cnt_n + 2'd1;
    end
  end

  // in_ready is a flop of "skid empty", so out_ready never reaches it combinationally.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) begin
        q[i] <= '0;
      end
      cnt        <= 2'd0;
      in_ready_r <= 1'b0;
    end else begin
      q          <= q_n;
      cnt        <= cnt_n;
      in_ready_r <= (cnt_n <= 2'd1);
    end
  end

`else

  assign in_ready = !reset && (!out_valid || out_ready);

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (in_fire) begin
      out_valid <= 1'b1;
      out_data  <= result;
      out_last  <= is_last;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`endif

endmodule

// File: tb/tb_addroundkey_pipe.sv
// Directed self-checking bench for addroundkey_pipe (default build, no skid buffer).
module tb_addroundkey_pipe;

  localparam int BB    = 16;
  localparam int LANES = 4;
  localparam int NKEYS = 11;
  localparam int KW    = 4;

  logic               clk = 1'b0;
  logic               reset;
  logic               key_wr_en;
  logic [KW-1:0]      key_wr_idx;
  logic [8*BB-1:0]    key_wr_data;
  logic               in_valid;
  logic               in_ready;
  logic [8*LANES-1:0] in_data;
  logic [KW-1:0]      in_round;
  logic               out_valid;
  logic               out_ready;
  logic [8*LANES-1:0] out_data;
  logic               out_last;
  logic               err_round;

  int checks = 0;
  int errors = 0;

  logic [127:0] kmod [NKEYS];

  addroundkey_pipe #(.BLOCK_BYTES(BB), .LANES(LANES), .NKEYS(NKEYS)) dut (
    .clk         (clk),
    .reset       (reset),
    .key_wr_en   (key_wr_en),
    .key_wr_idx  (key_wr_idx),
    .key_wr_data (key_wr_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_round    (in_round),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_last    (out_last),
    .err_round   (err_round)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_key(input logic [KW-1:0] idx, input logic [127:0] data);
    key_wr_en   = 1'b1;
    key_wr_idx  = idx;
    key_wr_data = data;
    tick();
    key_wr_en = 1'b0;
    if (idx < KW'(NKEYS)) kmod[idx] = data;
  endtask

  // Drive one beat, confirm it is accepted, then check the registered result.
  task automatic beat(input logic [31:0] data, input logic [KW-1:0] rnd,
                      input logic [31:0] exp, input logic last, input string tag);
    in_valid = 1'b1;
    in_data  = data;
    in_round = rnd;
    #1;
    check({tag, "_rdy"}, in_ready, 1'b1);
    tick();
    check({tag, "_vld"}, out_valid, 1'b1);
    check({tag, "_dat"}, out_data, exp);
    check({tag, "_lst"}, out_last, last);
  endtask

  task automatic send_block(input logic [127:0] blk, input logic [127:0] exp,
                            input logic [KW-1:0] r0, input logic [KW-1:0] rrest,
                            input string tag);
    for (int b = 0; b < 4; b++) begin
      beat(blk[32*b +: 32], (b == 0) ? r0 : rrest, exp[32*b +: 32], b == 3,
           $sformatf("%s_b%0d", tag, b));
    end
    in_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] k0, blk, exp;

    reset       = 1'b1;
    key_wr_en   = 1'b0;
    key_wr_idx  = '0;
    key_wr_data = '0;
    in_valid    = 1'b0;
    in_data     = '0;
    in_round    = '0;
    out_ready   = 1'b1;
    for (int k = 0; k < NKEYS; k++) kmod[k] = '0;
    tick();
    tick();
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 32'h0);
    check("rst_out_last", out_last, 1'b0);
    check("rst_err", err_round, 1'b0);
    reset = 1'b0;
    tick();

    // 1: hand-computed bytes 15/10/5, round 0
    k0 = '0;
    k0[15*8 +: 8] = 8'h4A;
    k0[10*8 +: 8] = 8'h7F;
    k0[5*8 +: 8]  = 8'h0D;
    write_key(4'd0, k0);
    for (int k = 0; k < 16; k++) blk[8*k +: 8] = 8'(16 + k);
    blk[15*8 +: 8] = 8'h1C;
    blk[10*8 +: 8] = 8'h06;
    blk[5*8 +: 8]  = 8'hC3;
    exp = blk;
    exp[15*8 +: 8] = 8'h56;
    exp[10*8 +: 8] = 8'h79;
    exp[5*8 +: 8]  = 8'hCE;
    send_block(blk, exp, 4'd0, 4'd0, "t1");
    tick();
    check("t1_idle_vld", out_valid, 1'b0);

    // 2: 3-cycle stall after beat 1
    blk = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
    exp = blk ^ kmod[0];
    beat(blk[31:0], 4'd0, exp[31:0], 1'b0, "t2_b0");
    beat(blk[63:32], 4'd0, exp[63:32], 1'b0, "t2_b1");
    out_ready = 1'b0;
    in_data   = blk[95:64];
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("t2_stall%0d_rdy", i), in_ready, 1'b0);
      tick();
      check($sformatf("t2_stall%0d_vld", i), out_valid, 1'b1);
      check($sformatf("t2_stall%0d_dat", i), out_data, exp[63:32]);
      check($sformatf("t2_stall%0d_lst", i), out_last, 1'b0);
    end
    out_ready = 1'b1;
    beat(blk[95:64], 4'd0, exp[95:64], 1'b0, "t2_b2");
    beat(blk[127:96], 4'd0, exp[127:96], 1'b1, "t2_b3");
    in_valid = 1'b0;

    // 3: round latched on beat 0 only
    write_key(4'd1, {16{8'h01}});
    write_key(4'd2, {16{8'hFF}});
    blk = 128'hDEADBEEF_01234567_89ABCDEF_C0FFEE00;
    send_block(blk, blk ^ {16{8'h01}}, 4'd1, 4'd2, "t3");

    // 4: same-cycle forwarding, then a mid-block write that must not disturb the block
    write_key(4'd3, {16{8'h55}});
    blk = 128'h11223344_55667788_99AABBCC_DDEEFF00;
    exp = blk ^ {16{8'hAA}};
    key_wr_en = 1'b1; key_wr_idx = 4'd3; key_wr_data = {16{8'hAA}};
    beat(blk[31:0], 4'd3, exp[31:0], 1'b0, "t4_b0");
    key_wr_data = {16{8'h33}};
    beat(blk[63:32], 4'd3, exp[63:32], 1'b0, "t4_b1");
    key_wr_en = 1'b0;
    kmod[3] = {16{8'h33}};
    beat(blk[95:64], 4'd3, exp[95:64], 1'b0, "t4_b2");
    beat(blk[127:96], 4'd3, exp[127:96], 1'b1, "t4_b3");
    in_valid = 1'b0;
    send_block(blk, blk ^ kmod[3], 4'd3, 4'd3, "t4_new");

    // 5: out-of-range round passes data through and sets the sticky error
    check("t5_err_before", err_round, 1'b0);
    blk = 128'hA5A5A5A5_5A5A5A5A_F00DCAFE_12345678;
    send_block(blk, blk, 4'd11, 4'd11, "t5");
    check("t5_err_set", err_round, 1'b1);
    write_key(4'd11, {16{8'hFF}});
    blk = 128'h00010203_04050607_08090A0B_0C0D0E0F;
    send_block(blk, blk ^ kmod[0], 4'd0, 4'd0, "t5_after");
    check("t5_err_sticky", err_round, 1'b1);

    // 6: reset mid-block clears keys, error and beat counter
    blk = 128'h76543210_FEDCBA98_13579BDF_2468ACE0;
    exp = blk ^ kmod[1];
    beat(blk[31:0], 4'd1, exp[31:0], 1'b0, "t6_b0");
    beat(blk[63:32], 4'd1, exp[63:32], 1'b0, "t6_b1");
    in_valid = 1'b0;
    reset    = 1'b1;
    #1;
    check("t6_rst_rdy", in_ready, 1'b0);
    tick();
    check("t6_rst_vld", out_valid, 1'b0);
    check("t6_rst_dat", out_data, 32'h0);
    check("t6_rst_err", err_round, 1'b0);
    reset = 1'b0;
    for (int k = 0; k < NKEYS; k++) kmod[k] = '0;
    tick();
    send_block(blk, blk, 4'd1, 4'd1, "t6_post");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
